// File: rtl/lrf_pkg.sv
// Shared LRF frame-ingress types and frame geometry, also used by the downstream buffer.
package lrf_pkg;

  typedef enum logic [1:0] {IDLE, PASS, PAD} lrf_state_e;

  localparam int LRF_FRAME_WIDTH  = 512;
  localparam int LRF_FRAME_HEIGHT = 512;
  localparam int LRF_TOTAL        = LRF_FRAME_WIDTH * LRF_FRAME_HEIGHT;

  // A one-pixel frame still needs a one-bit index.
  function automatic int lrf_idx_w(input int total);
    return (total > 1) ? $clog2(total) : 1;
  endfunction

  localparam int LRF_IDX_W = lrf_idx_w(LRF_TOTAL);

endpackage

// File: rtl/lrf_sync_fifo.sv
// First-word fall-through skid FIFO with registered full/empty flags.
module lrf_sync_fifo #(
  parameter int WIDTH = 10,
  parameter int DEPTH = 16
) (
  input  logic             aclk,
  input  logic             aresetn,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] head,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] DEPTH_C = DEPTH[AW:0];

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr, rd_ptr;
  logic [AW:0]      count, count_nxt;
  logic             do_push, do_pop;

  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;
  assign head    = mem[rd_ptr];

  always_comb begin
    count_nxt = count + {{AW{1'b0}}, do_push} - {{AW{1'b0}}, do_pop};
  end

  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      full   <= 1'b0;
      empty  <= 1'b1;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      count <= count_nxt;
      full  <= (count_nxt == DEPTH_C);
      empty <= (count_nxt == '0);
    end
  end

  always_ff @(posedge aclk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/lrf_frame_packer.sv
// Sensor pixel stream to fixed-size AXI4-Stream frames; repairs short, long and
// overflowed frames by zero-padding or discard, counting each case.
module lrf_frame_packer
  import lrf_pkg::*;
#(
  parameter int FRAME_WIDTH  = 512,
  parameter int FRAME_HEIGHT = 512,
  parameter int PIXEL_WIDTH  = 8,
  parameter int FIFO_DEPTH   = 16,
  parameter int CNT_WIDTH    = 16
) (
  input  logic                   aclk,
  input  logic                   aresetn,
  input  logic                   enable,
  input  logic [PIXEL_WIDTH-1:0] vid_data,
  input  logic                   vid_valid,
  input  logic                   vid_fs,
  output logic [PIXEL_WIDTH-1:0] m_axis_tdata,
  output logic                   m_axis_tvalid,
  input  logic                   m_axis_tready,
  output logic                   m_axis_tlast,
  output logic                   m_axis_tuser,
  output logic [CNT_WIDTH-1:0]   frame_count,
  output logic [CNT_WIDTH-1:0]   short_count,
  output logic [CNT_WIDTH-1:0]   ovf_count,
  output logic [CNT_WIDTH-1:0]   long_count,
  output logic [CNT_WIDTH-1:0]   drop_count
);

  localparam int TOTAL = FRAME_WIDTH * FRAME_HEIGHT;
  localparam int IDX_W = lrf_idx_w(TOTAL);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(TOTAL - 1);
  localparam int EW = PIXEL_WIDTH + 2;
  localparam int NCNT = 5;

  lrf_state_e state, state_nxt;
  logic [IDX_W-1:0] idx, idx_nxt;
  logic extra, extra_nxt;
  logic at_last, fs_ok;

  logic                   push, push_user, push_last;
  logic [PIXEL_WIDTH-1:0] push_data;
  logic [EW-1:0]          head;
  logic                   full, empty, pop;

  // Counter slots: 0 frame, 1 short, 2 ovf, 3 long, 4 drop.
  logic [NCNT-1:0]                inc;
  logic [NCNT-1:0][CNT_WIDTH-1:0] cnt;

  assign at_last = (idx == LAST_IDX);
  assign fs_ok   = vid_valid & vid_fs;

  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      state <= IDLE;
      idx   <= '0;
      extra <= 1'b0;
    end else begin
      state <= state_nxt;
      idx   <= idx_nxt;
      extra <= extra_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (fs_ok && enable && !full && !at_last) state_nxt = PASS;
      PASS:    if (vid_valid && (vid_fs || full))        state_nxt = PAD;
               else if (vid_valid && at_last)            state_nxt = IDLE;
      PAD:     if (!full && at_last)                     state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    push      = 1'b0;
    push_data = '0;
    push_user = 1'b0;
    inc[4:1]  = '0;
    extra_nxt = extra;
    unique case (state)
      IDLE: begin
        if (fs_ok) begin
          extra_nxt = 1'b0;
          if (enable && !full) begin
            push      = 1'b1;
            push_data = vid_data;
            push_user = 1'b1;
          end else begin
            inc[4] = 1'b1;
          end
        end else if (vid_valid && extra) begin
          inc[3]    = 1'b1;
          extra_nxt = 1'b0;
        end
      end
      PASS: begin
        if (vid_valid) begin
          if (vid_fs)     inc[1] = 1'b1;
          else if (full)  inc[2] = 1'b1;
          else begin
            push      = 1'b1;
            push_data = vid_data;
            // Any further non-fs pixel before the next start marks a long frame.
            if (at_last) extra_nxt = 1'b1;
          end
        end
      end
      PAD:     push = ~full;
      default: ;
    endcase
    push_last = push & at_last;
    inc[0]    = push_last;
    idx_nxt   = push ? (at_last ? '0 : idx + IDX_W'(1)) : idx;
  end

  assign pop = m_axis_tvalid & m_axis_tready;

  lrf_sync_fifo #(
    .WIDTH (EW),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .aclk      (aclk),
    .aresetn   (aresetn),
    .push      (push),
    .push_data ({push_data, push_last, push_user}),
    .pop       (pop),
    .head      (head),
    .full      (full),
    .empty     (empty)
  );

  assign m_axis_tvalid = ~empty;
  assign m_axis_tdata  = head[EW-1:2];
  assign m_axis_tlast  = head[1];
  assign m_axis_tuser  = head[0];

  for (genvar g = 0; g < NCNT; g++) begin : g_cnt
    always_ff @(posedge aclk) begin
      if (!aresetn)                  cnt[g] <= '0;
      else if (inc[g] && ~&cnt[g])   cnt[g] <= cnt[g] + CNT_WIDTH'(1);
    end
  end

  assign frame_count = cnt[0];
  assign short_count = cnt[1];
  assign ovf_count   = cnt[2];
  assign long_count  = cnt[3];
  assign drop_count  = cnt[4];

endmodule

// File: tb/tb_lrf_frame_packer.sv
// Self-checking bench for lrf_frame_packer: directed test-plan scenarios plus a
// randomized run against a frame-level reference model.
module tb_lrf_frame_packer;

  localparam int FW = 4, FH = 2, TOTAL = FW * FH, DEPTH = 4, PW = 8, CW = 16;

  logic          aclk = 1'b0;
  logic          aresetn = 1'b0;
  logic          enable = 1'b1;
  logic [PW-1:0] vid_data = '0;
  logic          vid_valid = 1'b0;
  logic          vid_fs = 1'b0;
  logic [PW-1:0] m_axis_tdata;
  logic          m_axis_tvalid;
  logic          m_axis_tready = 1'b1;
  logic          m_axis_tlast;
  logic          m_axis_tuser;
  logic [CW-1:0] frame_count, short_count, ovf_count, long_count, drop_count;

  int checks = 0;
  int failures = 0;
  bit mon_en = 1'b0;

  always #5 aclk = ~aclk;

  lrf_frame_packer #(
    .FRAME_WIDTH (FW), .FRAME_HEIGHT (FH), .PIXEL_WIDTH (PW),
    .FIFO_DEPTH (DEPTH), .CNT_WIDTH (CW)
  ) dut (
    .aclk (aclk), .aresetn (aresetn), .enable (enable),
    .vid_data (vid_data), .vid_valid (vid_valid), .vid_fs (vid_fs),
    .m_axis_tdata (m_axis_tdata), .m_axis_tvalid (m_axis_tvalid),
    .m_axis_tready (m_axis_tready), .m_axis_tlast (m_axis_tlast),
    .m_axis_tuser (m_axis_tuser),
    .frame_count (frame_count), .short_count (short_count), .ovf_count (ovf_count),
    .long_count (long_count), .drop_count (drop_count)
  );

  // Reference model: queue of beats in flight, frame mode (0 idle, 1 passing,
  // 2 padding), pixels already emitted in the current frame, surplus flag.
  logic [PW+1:0] mq[$];
  logic [PW+1:0] obs_q[$];
  int  m_mode = 0, m_pos = 0;
  bit  m_extra = 1'b0;
  int  m_cnt[5] = '{0, 0, 0, 0, 0};

  // Inputs change #1 after posedge; the negedge sees what the next posedge will sample.
  always @(negedge aclk) begin : mon
    logic [PW+1:0] ent;
    bit do_push, mfull;
    if (mon_en) begin
      mfull = (mq.size() == DEPTH);
      checks++;
      if (m_axis_tvalid !== (mq.size() != 0))
        $display("FAIL tvalid @%0t: got %b exp %b", $time, m_axis_tvalid, mq.size() != 0);
      if (m_axis_tvalid !== (mq.size() != 0)) failures++;
      if (mq.size() != 0 && m_axis_tready) begin
        checks++;
        if ({m_axis_tdata, m_axis_tlast, m_axis_tuser} !== mq[0]) begin
          failures++;
          $display("FAIL beat @%0t: got %h exp %h", $time,
                   {m_axis_tdata, m_axis_tlast, m_axis_tuser}, mq[0]);
        end
        obs_q.push_back({m_axis_tdata, m_axis_tlast, m_axis_tuser});
        void'(mq.pop_front());
      end
      if (!aresetn) begin
        mq.delete();
        m_mode = 0; m_pos = 0; m_extra = 1'b0;
        foreach (m_cnt[k]) m_cnt[k] = 0;
      end else begin
        do_push = 1'b0;
        ent = '0;
        case (m_mode)
          0: if (vid_valid && vid_fs) begin
               m_extra = 1'b0;
               if (enable && !mfull) begin
                 ent = {vid_data, 2'b01}; do_push = 1'b1; m_pos = 0; m_mode = 1;
               end else if (m_cnt[4] < 65535) m_cnt[4]++;
             end else if (vid_valid && m_extra) begin
               if (m_cnt[3] < 65535) m_cnt[3]++;
               m_extra = 1'b0;
             end
          1: if (vid_valid) begin
               if (vid_fs) begin
                 if (m_cnt[1] < 65535) m_cnt[1]++;
                 m_mode = 2;
               end else if (mfull) begin
                 if (m_cnt[2] < 65535) m_cnt[2]++;
                 m_mode = 2;
               end else begin
                 ent = {vid_data, 2'b00}; do_push = 1'b1;
               end
             end
          default: if (!mfull) begin ent = '0; do_push = 1'b1; end
        endcase
        if (do_push) begin
          if (m_pos == TOTAL - 1) begin
            ent[1] = 1'b1;
            if (m_cnt[0] < 65535) m_cnt[0]++;
            m_extra = (m_mode == 1);
            m_mode = 0;
            m_pos = 0;
          end else m_pos++;
          mq.push_back(ent);
        end
      end
    end
  end

  task automatic do_reset(input int n);
    aresetn = 1'b0; vid_valid = 1'b0; vid_fs = 1'b0;
    repeat (n) @(posedge aclk);
    #1 aresetn = 1'b1;
  endtask

  task automatic send(input logic fs, input logic [PW-1:0] d);
    vid_valid = 1'b1; vid_fs = fs; vid_data = d;
    @(posedge aclk); #1;
    vid_valid = 1'b0; vid_fs = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge aclk);
    #1;
  endtask

  task automatic test_reset;
    do_reset(3);
    @(negedge aclk);
    checks++;
    if (m_axis_tvalid !== 1'b0 ||
        {frame_count, short_count, ovf_count, long_count, drop_count} !== '0) begin
      failures++;
      $display("FAIL reset_state: tvalid=%b counters=%h exp 0", m_axis_tvalid,
               {frame_count, short_count, ovf_count, long_count, drop_count});
    end
    @(posedge aclk); #1;
  endtask

  task automatic test_clean;
    logic [PW+1:0] exp;
    do_reset(2); obs_q.delete(); m_axis_tready = 1'b1;
    for (int i = 0; i < TOTAL; i++) send(i == 0, PW'(i + 1));
    idle(10);
    checks++;
    if (obs_q.size() != TOTAL) begin
      failures++; $display("FAIL clean_len: got %0d exp %0d", obs_q.size(), TOTAL);
    end else for (int i = 0; i < TOTAL; i++) begin
      exp = {PW'(i + 1), i == TOTAL - 1, i == 0};
      checks++;
      if (obs_q[i] !== exp) begin
        failures++; $display("FAIL clean_beat%0d: got %h exp %h", i, obs_q[i], exp);
      end
    end
    checks++;
    if ({frame_count, short_count, ovf_count, long_count, drop_count} !== {16'd1, 64'd0}) begin
      failures++; $display("FAIL clean_counters: got %h exp frame=1 rest 0",
                           {frame_count, short_count, ovf_count, long_count, drop_count});
    end
  endtask

  task automatic test_short;
    logic [PW+1:0] exp;
    do_reset(2); obs_q.delete();
    for (int i = 0; i < 5; i++) send(i == 0, PW'(i + 1));
    for (int i = 0; i < TOTAL; i++) send(i == 0, PW'(i + 1));
    idle(10);
    checks++;
    if (obs_q.size() != TOTAL) begin
      failures++; $display("FAIL short_len: got %0d exp %0d", obs_q.size(), TOTAL);
    end else for (int i = 0; i < TOTAL; i++) begin
      exp = {(i < 5) ? PW'(i + 1) : PW'(0), i == TOTAL - 1, i == 0};
      checks++;
      if (obs_q[i] !== exp) begin
        failures++; $display("FAIL short_beat%0d: got %h exp %h", i, obs_q[i], exp);
      end
    end
    checks++;
    if ({frame_count, short_count, ovf_count, long_count, drop_count} !==
        {16'd1, 16'd1, 48'd0}) begin
      failures++; $display("FAIL short_counters: got %h exp frame=1 short=1",
                           {frame_count, short_count, ovf_count, long_count, drop_count});
    end
  endtask

  task automatic test_overflow;
    logic [PW+1:0] exp;
    do_reset(2); obs_q.delete(); m_axis_tready = 1'b0;
    for (int i = 0; i < TOTAL; i++) send(i == 0, PW'(i + 1));
    idle(3);
    checks++;
    if (ovf_count !== 16'd1 || obs_q.size() != 0) begin
      failures++; $display("FAIL ovf_stall: ovf=%0d beats=%0d exp 1 and 0", ovf_count, obs_q.size());
    end
    m_axis_tready = 1'b1;
    idle(15);
    checks++;
    if (obs_q.size() != TOTAL) begin
      failures++; $display("FAIL ovf_len: got %0d exp %0d", obs_q.size(), TOTAL);
    end else for (int i = 0; i < TOTAL; i++) begin
      exp = {(i < DEPTH) ? PW'(i + 1) : PW'(0), i == TOTAL - 1, i == 0};
      checks++;
      if (obs_q[i] !== exp) begin
        failures++; $display("FAIL ovf_beat%0d: got %h exp %h", i, obs_q[i], exp);
      end
    end
    checks++;
    if ({frame_count, short_count, ovf_count, long_count, drop_count} !==
        {16'd1, 16'd0, 16'd1, 32'd0}) begin
      failures++; $display("FAIL ovf_counters: got %h exp frame=1 ovf=1",
                           {frame_count, short_count, ovf_count, long_count, drop_count});
    end
  endtask

  task automatic test_long;
    logic [PW+1:0] exp;
    do_reset(2); obs_q.delete();
    for (int i = 0; i < TOTAL + 3; i++) send(i == 0, PW'(i + 1));
    for (int i = 0; i < TOTAL; i++) send(i == 0, PW'(8'h40 + i));
    idle(10);
    checks++;
    if (obs_q.size() != 2 * TOTAL) begin
      failures++; $display("FAIL long_len: got %0d exp %0d", obs_q.size(), 2 * TOTAL);
    end else for (int i = 0; i < 2 * TOTAL; i++) begin
      exp = {(i < TOTAL) ? PW'(i + 1) : PW'(8'h40 + i - TOTAL),
             (i % TOTAL) == TOTAL - 1, (i % TOTAL) == 0};
      checks++;
      if (obs_q[i] !== exp) begin
        failures++; $display("FAIL long_beat%0d: got %h exp %h", i, obs_q[i], exp);
      end
    end
    checks++;
    if ({frame_count, short_count, ovf_count, long_count, drop_count} !==
        {16'd2, 32'd0, 16'd1, 16'd0}) begin
      failures++; $display("FAIL long_counters: got %h exp frame=2 long=1",
                           {frame_count, short_count, ovf_count, long_count, drop_count});
    end
  endtask

  task automatic test_enable;
    do_reset(2); obs_q.delete();
    enable = 1'b0;
    for (int i = 0; i < TOTAL; i++) send(i == 0, PW'(i + 1));
    idle(5);
    checks++;
    if (drop_count !== 16'd1 || obs_q.size() != 0) begin
      failures++; $display("FAIL enable_drop: drop=%0d beats=%0d exp 1 and 0", drop_count, obs_q.size());
    end
    enable = 1'b1;
    for (int i = 0; i < TOTAL; i++) begin
      send(i == 0, PW'(8'h80 + i));
      if (i == 2) enable = 1'b0;
    end
    idle(10);
    enable = 1'b1;
    checks++;
    if (obs_q.size() != TOTAL || frame_count !== 16'd1 || drop_count !== 16'd1 ||
        long_count !== 16'd0) begin
      failures++; $display("FAIL enable_mid: beats=%0d frame=%0d drop=%0d long=%0d exp 8,1,1,0",
                           obs_q.size(), frame_count, drop_count, long_count);
    end else begin
      checks++;
      if (obs_q[0] !== {8'h80, 2'b01} || obs_q[TOTAL-1] !== {8'h87, 2'b10}) begin
        failures++; $display("FAIL enable_beats: got %h/%h exp 201/21e", obs_q[0], obs_q[TOTAL-1]);
      end
    end
  endtask

  task automatic test_reset_mid;
    do_reset(2); obs_q.delete(); m_axis_tready = 1'b0;
    for (int i = 0; i < 3; i++) send(i == 0, PW'(i + 1));
    do_reset(1);
    @(negedge aclk);
    checks++;
    if (m_axis_tvalid !== 1'b0 ||
        {frame_count, short_count, ovf_count, long_count, drop_count} !== '0) begin
      failures++; $display("FAIL reset_mid: tvalid=%b counters=%h exp 0", m_axis_tvalid,
                           {frame_count, short_count, ovf_count, long_count, drop_count});
    end
    @(posedge aclk); #1;
    m_axis_tready = 1'b1;
    for (int i = 0; i < TOTAL; i++) send(i == 0, PW'(8'hc0 + i));
    idle(10);
    checks++;
    if (obs_q.size() != TOTAL || obs_q[0] !== {8'hc0, 2'b01} ||
        obs_q[TOTAL-1] !== {8'hc7, 2'b10} || frame_count !== 16'd1) begin
      failures++; $display("FAIL reset_mid_frame: beats=%0d frame=%0d exp 8 beats c0..c7, frame=1",
                           obs_q.size(), frame_count);
    end
  endtask

  task automatic test_random;
    do_reset(2);
    for (int c = 0; c < 4000; c++) begin
      m_axis_tready = ($urandom_range(3) != 0);
      enable        = ($urandom_range(7) != 0);
      vid_valid     = ($urandom_range(3) != 0);
      vid_fs        = vid_valid && ($urandom_range(9) == 0);
      vid_data      = PW'($urandom);
      aresetn       = ($urandom_range(499) != 0);
      @(posedge aclk); #1;
    end
    aresetn = 1'b1; vid_valid = 1'b0; vid_fs = 1'b0; m_axis_tready = 1'b1;
    idle(30);
    checks++;
    if ({frame_count, short_count, ovf_count, long_count, drop_count} !==
        {CW'(m_cnt[0]), CW'(m_cnt[1]), CW'(m_cnt[2]), CW'(m_cnt[3]), CW'(m_cnt[4])}) begin
      failures++;
      $display("FAIL random_counters: got %0d/%0d/%0d/%0d/%0d exp %0d/%0d/%0d/%0d/%0d",
               frame_count, short_count, ovf_count, long_count, drop_count,
               m_cnt[0], m_cnt[1], m_cnt[2], m_cnt[3], m_cnt[4]);
    end
    checks++;
    if (m_cnt[0] == 0 || m_cnt[1] == 0) begin
      failures++; $display("FAIL random_coverage: frames=%0d shorts=%0d exp both nonzero",
                           m_cnt[0], m_cnt[1]);
    end
  endtask

  initial begin
    @(posedge aclk); #1;
    mon_en = 1'b1;
    test_reset;
    test_clean;
    test_short;
    test_overflow;
    test_long;
    test_enable;
    test_reset_mid;
    test_random;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/lrf_frame_packer.md
Name: lrf_frame_packer

Overview:
- Ingress stage directly upstream of the LRF 32-frame buffer.
- Converts a free-running sensor pixel stream (valid + frame-start, no backpressure) into AXI4-Stream frames.
- Every emitted frame is exactly FRAME_WIDTH*FRAME_HEIGHT pixels, with tuser on the first pixel and tlast on the last.
- Absorbs downstream stalls in a small FIFO. Short, long and overflowed frames are repaired by zero-padding or discard, and each case is counted.

Parameters:
FRAME_WIDTH, 512, pixels per line
FRAME_HEIGHT, 512, lines per frame
PIXEL_WIDTH, 8, bits per pixel
FIFO_DEPTH, 16, skid FIFO entries (power of 2, >=4)
CNT_WIDTH, 16, status counter width

Ports:
aclk  in  1  clock
aresetn  in  1  synchronous active-low reset
enable  in  1  allow new frames to start; sampled only at frame start
vid_data  in  PIXEL_WIDTH  sensor pixel
vid_valid  in  1  pixel present this cycle (no backpressure)
vid_fs  in  1  frame start, qualified by vid_valid, coincident with pixel 0
m_axis_tdata  out  PIXEL_WIDTH  output pixel
m_axis_tvalid  out  1  output valid
m_axis_tready  in  1  downstream ready
m_axis_tlast  out  1  last pixel of frame
m_axis_tuser  out  1  first pixel of frame
frame_count  out  CNT_WIDTH  frames emitted (tlast pushed)
short_count  out  CNT_WIDTH  frames ended early by vid_fs, then padded
ovf_count  out  CNT_WIDTH  frames truncated by FIFO full, then padded
long_count  out  CNT_WIDTH  frames followed by surplus pixels
drop_count  out  CNT_WIDTH  frame starts discarded entirely

Behaviour:
- Interface: reset aresetn, synchronous, active-low; clock aclk. All state updates on the aclk rising edge.
- Reset:
  - FSM goes to IDLE; pixel index = 0; FIFO emptied; all counters = 0; extra flag = 0.
  - m_axis_tvalid = 0. m_axis_tdata, tlast and tuser drive the FIFO head; their value is don't-care while tvalid = 0.
  - Reset mid-frame discards everything, including FIFO contents. No partial-frame flush.
- TOTAL = FRAME_WIDTH*FRAME_HEIGHT. Index width = $clog2(TOTAL).
- Each FIFO entry is {data, last, user}. The FIFO is first-word fall-through:
  - m_axis_tvalid = !empty; m_axis_* = head.
  - Pop on tvalid & tready.
  - A push into a full FIFO never occurs by construction.
  - Latency: a pixel pushed in cycle N is visible on m_axis in cycle N+1.
  - Push and pop in the same cycle are allowed when full (pop frees the slot next cycle; the FSM uses registered full).
- Push-with-last rule: whenever the pushed index == TOTAL-1, the entry gets last=1, frame_count increments, index clears, and the FSM goes to IDLE.
- IDLE:
  - vid_valid & vid_fs & enable & !full: push pixel (user=1, index 0), clear extra flag, go to PASS. Special case TOTAL==1: last=1 and stay in IDLE.
  - vid_valid & vid_fs & (!enable | full): drop_count++, clear extra flag, stay in IDLE.
  - vid_valid & !vid_fs: discard the pixel. If the extra flag is 1: long_count++ and clear the flag (counted once per frame).
- PASS:
  - vid_valid & vid_fs (early start): discard the pixel, short_count++, go to PAD. The new frame is lost and is not counted in drop_count.
  - vid_valid & !vid_fs & full: discard the pixel, ovf_count++, go to PAD.
  - vid_valid & !vid_fs & !full: push (user=0), index++. On index TOTAL-1, apply the push-with-last rule and set the extra flag.
  - !vid_valid: hold.
- PAD:
  - Each cycle with !full: push data 0 (user=0), index++; the push-with-last rule ends the frame (extra flag left 0).
  - All vid pixels received in PAD are discarded uncounted, including vid_fs.
- enable deasserted mid-frame has no effect; the current frame completes.
- Counters saturate at all-ones.

Decomposition:
- Package lrf_pkg:
  - FSM state enum {IDLE, PASS, PAD}.
  - Shared frame-geometry localparams (TOTAL, index width), also used by the downstream buffer.
- Sub-module lrf_sync_fifo:
  - Parameterised width/depth, first-word fall-through.
  - Registered full/empty.
  - Stores {tdata, tlast, tuser}.
- Top level holds the FSM, index and counters.

Test Plan (FRAME_WIDTH=4, FRAME_HEIGHT=2, TOTAL=8, FIFO_DEPTH=4 unless noted):
1. Clean frame: vid_fs + pixels 1..8 back-to-back, tready=1 -> 8 beats 1..8; tuser on beat 1, tlast on beat 8; frame_count=1; all other counters 0.
2. Short frame: 5 pixels 1..5, then vid_fs + 8 pixels -> beats 1,2,3,4,5,0,0,0 with tlast on beat 8; short_count=1; second frame not emitted; frame_count=1.
3. Overflow: tready=0, 8-pixel frame -> FIFO fills with 4 pixels, ovf_count=1; tready=1 -> beats 1..4 then 0,0,0,0 with tlast; frame_count=1.
4. Long frame: vid_fs + 11 pixels -> 8 beats emitted; long_count=1 (not 3); next vid_fs starts a clean frame.
5. enable=0 at vid_fs -> drop_count=1, no beats. Then enable=1 and a new frame -> emitted normally. enable dropped mid-frame -> frame still completes.
6. Reset mid-frame with FIFO non-empty -> tvalid=0 the cycle after reset; counters 0. Next vid_fs frame is emitted correctly with tuser on its first beat.
